// File: rtl/systolic_result_drain_pkg.sv
// systolic_result_drain_pkg: shared drain state type, frame header and element sizing helper
package systolic_result_drain_pkg;
  typedef enum logic [1:0] {IDLE, HDR, SEND, CSUM} drain_state_e;
  localparam logic [7:0] DRAIN_HDR = 8'hA5;
  function automatic int bytes_per_elem(input int out_width);
    return out_width / 8;
  endfunction
endpackage

// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: valid/ready byte stream towards the UART transmitter
interface systolic_result_drain_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/systolic_result_drain_byte_mux.sv
// drain_byte_mux: picks byte byte_idx (MSB first) of element elem from the result snapshot
module drain_byte_mux
  import systolic_result_drain_pkg::*;
#(
  parameter int N = 4,
  parameter int OUT_WIDTH = 16,
  parameter int EW = 4,
  parameter int BW = 1
) (
  input  logic [N*N*OUT_WIDTH-1:0] snapshot,
  input  logic [EW-1:0]            elem,
  input  logic [BW-1:0]            byte_idx,
  output logic [7:0]               data
);
  localparam int BPE = bytes_per_elem(OUT_WIDTH);
  always_comb data = snapshot[int'(elem)*OUT_WIDTH + (BPE-1-int'(byte_idx))*8 +: 8];
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the PE array results and streams them as bytes; DRAIN_FRAME_EN adds header/XOR checksum framing
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int N = 4,
  parameter int OUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N*N*OUT_WIDTH-1:0] c_flat,
  output logic                     array_clear,
  output logic                     busy,
  output logic                     done,
  systolic_result_drain_if.master  tx
);
  localparam int BPE = bytes_per_elem(OUT_WIDTH);
  localparam int EW = (N*N > 1) ? $clog2(N*N) : 1;
  localparam int BW = (BPE > 1) ? $clog2(BPE) : 1;
  drain_state_e state, next;
  logic [N*N*OUT_WIDTH-1:0] snapshot;
  logic [EW-1:0] elem;
  logic [BW-1:0] byte_idx;
  logic [7:0] payload_byte;
  logic xfer, byte_wrap, last;
  logic take;
`ifdef DRAIN_FRAME_EN
  logic [7:0] csum;
`endif
  drain_byte_mux #(.N(N), .OUT_WIDTH(OUT_WIDTH), .EW(EW), .BW(BW)) u_mux (
    .snapshot(snapshot),
    .elem(elem),
    .byte_idx(byte_idx),
    .data(payload_byte)
  );
  assign xfer = tx.tx_valid && tx.tx_ready;
  assign byte_wrap = byte_idx == BW'(BPE-1);
  assign last = byte_wrap && (elem == EW'(N*N-1));
  assign take = (state == IDLE) && start;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    tx.tx_valid = 1'b0;
    tx.tx_data = 8'h00;
    case (state)
      IDLE: begin
`ifdef DRAIN_FRAME_EN
        if (start) next = HDR;
`else
        if (start) next = SEND;
`endif
      end
`ifdef DRAIN_FRAME_EN
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data = DRAIN_HDR;
        if (tx.tx_ready) next = SEND;
      end
      CSUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data = csum;
        if (tx.tx_ready) next = IDLE;
      end
`endif
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data = payload_byte;
`ifdef DRAIN_FRAME_EN
        if (tx.tx_ready && last) next = CSUM;
`else
        if (tx.tx_ready && last) next = IDLE;
`endif
      end
      default: next = IDLE;
    endcase
  end
  // snapshot is deliberately left out of reset: it is always reloaded on start
  always_ff @(posedge clk) begin
    if (reset) begin
      array_clear <= 1'b0;
      done <= 1'b0;
      elem <= '0;
      byte_idx <= '0;
    end else begin
      array_clear <= take;
      done <= (state != IDLE) && (next == IDLE);
      if (take) begin
        snapshot <= c_flat;
        elem <= '0;
        byte_idx <= '0;
      end else if (state == SEND && xfer) begin
        byte_idx <= byte_wrap ? '0 : byte_idx + 1'b1;
        elem <= elem + EW'(byte_wrap);
      end
    end
  end
`ifdef DRAIN_FRAME_EN
  always_ff @(posedge clk)
    if (reset || take) csum <= 8'h00;
    else if (state == SEND && xfer) csum <= csum ^ payload_byte;
`endif
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: directed checks of byte order, backpressure, snapshot, reset abort and back-to-back starts
module tb_systolic_result_drain;
  localparam int N = 4;
  localparam int W = 16;
`ifdef DRAIN_FRAME_EN
  localparam int DRAIN_CYC = N*N*W/8 + 2;
`else
  localparam int DRAIN_CYC = N*N*W/8;
`endif
  logic clk = 1'b0;
  logic reset, start, array_clear, busy, done;
  logic [N*N*W-1:0] c_flat;
  systolic_result_drain_if bus();
  systolic_result_drain #(.N(N), .OUT_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .c_flat(c_flat),
    .array_clear(array_clear),
    .busy(busy),
    .done(done),
    .tx(bus)
  );
  always #5 clk = ~clk;
  int check_cnt = 0;
  int pass_cnt = 0;
  logic [W-1:0] elems[N*N];
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  int ac_cnt;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask
  task automatic load_pattern(input int kind);
    for (int i = 0; i < N*N; i++) begin
      case (kind)
        0: elems[i] = 16'h0101 * 16'(i);
        1: elems[i] = 16'h1234;
        2: elems[i] = (i == 0) ? 16'h0001 : 16'h0000;
        default: elems[i] = 16'hFFFF;
      endcase
      c_flat[i*W +: W] = elems[i];
    end
  endtask
  task automatic build_exp();
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
`ifdef DRAIN_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < N*N; i++) begin
      exp_q.push_back(elems[i][15:8]);
      exp_q.push_back(elems[i][7:0]);
      x = x ^ elems[i][15:8] ^ elems[i][7:0];
    end
`ifdef DRAIN_FRAME_EN
    exp_q.push_back(x);
`endif
  endtask
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic collect(input bit rnd, input int stop, output int cycles, output bit got_done);
    bit pend;
    logic [7:0] pdata;
    cycles = 0;
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (array_clear) ac_cnt++;
      bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pend = bus.tx_valid && !bus.tx_ready;
      pdata = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
      @(posedge clk); #1;
      cycles++;
      if (pend) check("hold", {bus.tx_valid, bus.tx_data}, {1'b1, pdata});
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (stop != 0 && rx.size() == stop) break;
    end
  endtask
  task automatic compare_rx(input string tag);
    check({tag, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) check({tag, "_byte"}, rx[i], exp_q[i]);
  endtask
  initial begin
    int cyc, ndone;
    bit gd;
    reset = 1'b1;
    start = 1'b0;
    bus.tx_ready = 1'b0;
    c_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.tx_valid, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clear", array_clear, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    // plain drain with tx_ready held high
    load_pattern(0);
    build_exp();
    rx.delete();
    ac_cnt = 0;
    do_start();
    check("t1_clear", array_clear, 1);
    check("t1_valid", bus.tx_valid, 1);
    check("t1_busy", busy, 1);
    check("t1_first", bus.tx_data, exp_q[0]);
    collect(1'b0, 0, cyc, gd);
    check("t1_done", gd, 1);
    check("t1_cycles", cyc, DRAIN_CYC);
    check("t1_clear_cnt", ac_cnt, 1);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_valid", bus.tx_valid, 0);
    compare_rx("t1");
    // back-to-back start in the done cycle, then c_flat changes and a stray start
    rx.delete();
    ac_cnt = 0;
    do_start();
    check("b2b_busy", busy, 1);
    check("b2b_clear", array_clear, 1);
    load_pattern(3);
    collect(1'b0, 5, cyc, gd);
    start = 1'b1;
    collect(1'b0, 6, cyc, gd);
    start = 1'b0;
    collect(1'b0, 0, cyc, gd);
    check("snap_done", gd, 1);
    check("snap_clear_cnt", ac_cnt, 1);
    compare_rx("snap");
    // random backpressure
    load_pattern(0);
    @(posedge clk); #1;
    rx.delete();
    do_start();
    collect(1'b1, 0, cyc, gd);
    check("bp_done", gd, 1);
    compare_rx("bp");
    @(posedge clk); #1;
    check("bp_done_pulse", done, 0);
    // reset after 10 bytes
    rx.delete();
    do_start();
    collect(1'b0, 10, cyc, gd);
    check("rst10_bytes", rx.size(), 10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", bus.tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", bus.tx_data, 0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || bus.tx_valid) ndone++;
      @(posedge clk); #1;
    end
    check("abort_quiet", ndone, 0);
    rx.delete();
    do_start();
    collect(1'b0, 0, cyc, gd);
    check("restart_done", gd, 1);
    compare_rx("restart");
    // framing vectors: all 1234, then a single 0001
    load_pattern(1);
    build_exp();
    rx.delete();
    do_start();
    collect(1'b0, 0, cyc, gd);
    compare_rx("f1234");
`ifdef DRAIN_FRAME_EN
    check("f1234_hdr", rx[0], 8'hA5);
    check("f1234_csum", rx[rx.size()-1], 8'h00);
`endif
    load_pattern(2);
    build_exp();
    rx.delete();
    do_start();
    collect(1'b0, 0, cyc, gd);
    compare_rx("f0001");
`ifdef DRAIN_FRAME_EN
    check("f0001_csum", rx[rx.size()-1], 8'h01);
`else
    check("f0001_lsb", rx[1], 8'h01);
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
